// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: sends one command byte to the keyboard over the
// shared open-collector clock/data lines, with inhibit/request, ack check and timeout.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | lines released, ready for a new byte
// INHIBIT   | host holds PS/2 clock low for INHIBIT_CYCLES
// REQ       | host pulls data low (start bit) while still holding clock
// START     | clock released, waiting for the device's first falling edge
// SHIFT     | presenting data bits, parity and stop on each falling edge
// ACK       | waiting for the 11th fall to sample the device ack
// WAIT_IDLE | ack seen, waiting for both lines to return high
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES) + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int FLT_W = $clog2(FILTER_LEN) + 1;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        START,
        SHIFT,
        ACK,
        WAIT_IDLE
    } state_t;

    logic [1:0]       clk_sync;
    logic [1:0]       data_sync;
    logic             clk_filt;
    logic             fall;
    logic [FLT_W-1:0] flt_cnt;

    state_t           state, state_nxt;
    logic [INH_W-1:0] inh_cnt, inh_nxt;
    logic [TO_W-1:0]  to_cnt, to_nxt;
    logic [3:0]       bit_cnt, bit_nxt;
    logic [9:0]       shreg, sh_nxt;
    logic             bit_q, bitq_nxt;
    logic             to_active;
    logic             timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_filt <= 1'b1;
            flt_cnt  <= '0;
            fall     <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (clk_sync[1] == clk_filt) begin
                flt_cnt <= '0;
            end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                flt_cnt  <= '0;
                fall     <= ~clk_sync[1];
            end else begin
                flt_cnt <= flt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            inh_cnt <= '0;
            to_cnt  <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            bit_q   <= 1'b1;
        end else begin
            state   <= state_nxt;
            inh_cnt <= inh_nxt;
            to_cnt  <= to_nxt;
            bit_cnt <= bit_nxt;
            shreg   <= sh_nxt;
            bit_q   <= bitq_nxt;
        end
    end

    assign to_active = (state == START) || (state == SHIFT) ||
                       (state == ACK)   || (state == WAIT_IDLE);
    assign timeout   = to_active && (to_cnt == TO_W'(TIMEOUT_CYCLES));

    always_comb begin
        state_nxt   = state;
        inh_nxt     = inh_cnt;
        to_nxt      = to_cnt;
        bit_nxt     = bit_cnt;
        sh_nxt      = shreg;
        bitq_nxt    = bit_q;
        tx_ready    = 1'b0;
        tx_done     = 1'b0;
        tx_err      = 1'b0;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;

        if (to_active) begin
            to_nxt = to_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) begin
                    state_nxt = INHIBIT;
                    inh_nxt   = '0;
                    // Frame LSB first: data, odd parity, stop.
                    sh_nxt    = {1'b1, ~^tx_data, tx_data};
                end
            end
            INHIBIT: begin
                ps2_clk_oe = 1'b1;
                inh_nxt    = inh_cnt + 1'b1;
                if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = 1'b1;
                to_nxt      = '0;
                state_nxt   = START;
            end
            START: begin
                ps2_data_oe = 1'b1;
                if (fall) begin
                    bitq_nxt  = shreg[0];
                    sh_nxt    = {1'b1, shreg[9:1]};
                    bit_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                ps2_data_oe = ~bit_q;
                if (fall) begin
                    bitq_nxt = shreg[0];
                    sh_nxt   = {1'b1, shreg[9:1]};
                    bit_nxt  = bit_cnt + 1'b1;
                    if (bit_cnt == 4'd8) begin
                        state_nxt = ACK;
                    end
                end
            end
            ACK: begin
                ps2_data_oe = ~bit_q;
                if (fall) begin
                    if (!data_sync[1]) begin
                        state_nxt = WAIT_IDLE;
                    end else begin
                        tx_err    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (clk_filt && data_sync[1]) begin
                    tx_done   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Timeout wins over anything else happening in the same cycle.
        if (timeout) begin
            state_nxt   = IDLE;
            tx_done     = 1'b0;
            tx_err      = 1'b1;
            ps2_clk_oe  = 1'b0;
            ps2_data_oe = 1'b0;
        end
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xED set-LEDs, 0xF4 enable) from the FPGA to the keyboard.
- Complements the existing device-to-host keyboard receiver on the same two open-collector lines.
- Runs on the system clock. Watches the keyboard-generated PS/2 clock through a synchronizer and glitch filter.
- Drives each line low via an output-enable; the top level ties the pad to 0 when enabled and to Z otherwise.

Parameters:
- INHIBIT_CYCLES, 5000: system-clock cycles the host holds PS/2 clock low before the request (100 us at 50 MHz).
- TIMEOUT_CYCLES, 1000000: maximum cycles from clock release to ack completion (20 ms at 50 MHz).
- FILTER_LEN, 4: consecutive identical synchronized samples required before the filtered PS/2 clock changes.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- tx_data, input, 8: command byte.
- tx_valid, input, 1: request. Accepted only when tx_valid=1 and tx_ready=1.
- tx_ready, output, 1: high only in IDLE.
- tx_done, output, 1: one-cycle pulse on successful, acknowledged transfer.
- tx_err, output, 1: one-cycle pulse on missing ack or timeout.
- ps2_clk_in, input, 1: PS/2 clock pad level (asynchronous).
- ps2_data_in, input, 1: PS/2 data pad level (asynchronous).
- ps2_clk_oe, output, 1: 1 pulls PS/2 clock low.
- ps2_data_oe, output, 1: 1 pulls PS/2 data low.

Behaviour:
- Reset (async, rst_n=0): state IDLE; tx_ready=1; tx_done=0; tx_err=0; ps2_clk_oe=0; ps2_data_oe=0; counters 0. Synchronizer and filter registers reset to 1 (idle bus). The same applies mid-transfer: both lines are released immediately.
- Input conditioning:
  - Each pad input passes through a 2-FF synchronizer.
  - The clock is filtered: the filtered value updates only after FILTER_LEN equal samples.
  - fall = filtered clock 1->0, registered as a single-cycle strobe.
  - Data is sampled through its synchronized copy only.
- Parity: par = ~^tx_data (odd parity). tx_data and par are latched at accept; later changes on tx_data are ignored.
- Bit mapping: ps2_data_oe = ~bit, i.e. a 0 bit is driven low and a 1 bit is released.
- States:
  - IDLE: oe both 0. On accept, go to INHIBIT; tx_ready=0 from the next cycle.
  - INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then REQ.
  - REQ: clk_oe=1, data_oe=1 (start bit) for 1 cycle, then START. Timeout counter cleared.
  - START: clk_oe=0, data_oe=1. Falls seen while the host drove the clock are ignored. On the first fall, present bit0; bitcnt=0; go to SHIFT.
  - SHIFT: on each fall, bitcnt+1 and present the next item: bits 1..7, then parity on the 9th fall, then stop (data_oe=0) on the 10th fall; the 10th fall moves to ACK.
  - ACK: on the 11th fall, sample synced data. If 0, go to WAIT_IDLE. If 1, pulse tx_err and go to IDLE.
  - WAIT_IDLE: when filtered clock=1 and synced data=1, pulse tx_done and go to IDLE.
- Timeout:
  - Counter runs in START, SHIFT, ACK and WAIT_IDLE.
  - Reaching TIMEOUT_CYCLES: release both lines that cycle, pulse tx_err, go to IDLE.
  - Timeout has priority over a simultaneous fall.
- Pulses and ready:
  - tx_done and tx_err never assert in the same cycle.
  - tx_ready returns to 1 on the cycle after either pulse.
- Bus and requests:
  - The block never drives the clock outside INHIBIT and REQ.
  - data_oe changes only on a fall or a state entry.
  - tx_valid while not ready is ignored; no queuing.
- Counter widths are $clog2 of the respective parameter + 1.

Test Plan:
- Bench parameters: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=3000, FILTER_LEN=2. Device model: clock period ~80 cycles, acks by pulling data low after the 10th rise.
- Send 0xED -> clk_oe high 20 cycles, then data_oe=1 with clk_oe=0. data_oe after falls 1..10 = 0,1,0,0,1,0,0,0,0,0 (parity 1, stop released). Ack seen, lines idle -> tx_done single pulse, tx_ready=1.
- Send 0xF4 (parity 0) -> data_oe after falls 1..10 = 1,1,0,1,0,0,0,0,1,0. tx_done.
- Device withholds ack (data high at 11th fall) -> tx_err pulse, no tx_done, both oe 0, tx_ready=1.
- Device never clocks after release -> tx_err exactly TIMEOUT_CYCLES after REQ exit; lines released.
- 1-cycle glitch low on ps2_clk_in during SHIFT -> no extra bit; byte 0xED still sent correctly.
- rst_n low during SHIFT after fall 4 -> oe both 0 immediately, tx_ready=1 while held. A new 0x55 sent after release completes with tx_done.
- tx_valid held with 0xAA during an active transfer -> ignored; only one transfer of the original byte.
